float_div_seq: RTL and testbench

- Multi-cycle IEEE-style floating-point divider, C = A / B, for F16/F32/F64 selected by DATA_WIDTH.
- Inverse companion to the team's combinational float multiplier; uses the same field layout, the same exponent-bias arithmetic, and the same truncating and special-case simplifications.
- Sits in the CNN datapath behind valid/ready handshakes, used for normalisation/averaging.
- Uses an iterative restoring mantissa divider, one quotient bit per clock.

---
 rtl/float_pkg.sv | 35 +++
 rtl/float_frac_div.sv | 42 ++++
 rtl/float_div_seq.sv | 94 +++++++++
 tb/tb_float_div_seq.sv | 135 +++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// float_pkg: format constants, FSM state type and field helpers shared by the float arithmetic blocks.
package float_pkg;

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    // Unsupported widths fall back to F32.
    function automatic int legal_w(int dw);
        return (dw == 16 || dw == 64) ? dw : 32;
    endfunction

    function automatic int exp_w(int dw);
        return dw == 16 ? 5 : dw == 64 ? 11 : 8;
    endfunction

    function automatic int man_w(int dw);
        return dw == 16 ? 10 : dw == 64 ? 52 : 23;
    endfunction

    function automatic int exp_off(int dw);
        return (1 << (exp_w(dw) - 1)) - 1;
    endfunction

    function automatic logic f_sign(logic [63:0] x, int dw);
        return x[legal_w(dw)-1];
    endfunction

    function automatic logic [63:0] f_exp(logic [63:0] x, int dw);
        return (x >> man_w(dw)) & ((64'd1 << exp_w(dw)) - 64'd1);
    endfunction

    function automatic logic [63:0] f_man(logic [63:0] x, int dw);
        return x & ((64'd1 << man_w(dw)) - 64'd1);
    endfunction

endpackage

// File: rtl/float_frac_div.sv
// float_frac_div: restoring divider for normalised significands, one quotient bit per clock.
module float_frac_div #(
    parameter int M = 23
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] a_m,
    input  logic [M-1:0] b_m,
    output logic         done,
    output logic [M+1:0] quotient
);
    localparam int CW = $clog2(M + 3);

    logic [M+1:0] rem;
    logic [M+1:0] den;
    logic [CW-1:0] cnt;
    logic ge;

    assign ge = rem >= den;
    assign done = cnt == CW'(1);

    // rem stays below 2*den, so M+2 bits never overflow after the shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
            den <= '0;
            quotient <= '0;
            cnt <= '0;
        end else if (start) begin
            rem <= {2'b01, a_m};
            den <= {2'b01, b_m};
            quotient <= '0;
            cnt <= CW'(M + 2);
        end else if (cnt != '0) begin
            rem <= (ge ? rem - den : rem) << 1;
            quotient <= {quotient[M:0], ge};
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/float_div_seq.sv
// float_div_seq: multi-cycle truncating float divider C = A / B with valid/ready handshakes.
module float_div_seq
    import float_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_c,
    output logic                  out_dbz
);
    localparam int DW = legal_w(DATA_WIDTH);
    localparam int E = exp_w(DATA_WIDTH);
    localparam int M = man_w(DATA_WIDTH);
    localparam logic [E-1:0] OFF = E'(exp_off(DATA_WIDTH));

    state_t state, state_n;
    logic [DW-1:0] a, b, c_q;
    logic [E-1:0] ea, eb, exp_q;
    logic [M-1:0] ma, mb;
    logic [M+1:0] q;
    logic sa, sb, sign_q, dbz_q, a_zero, b_zero, accept, div_done;

    assign a = DW'(in_a);
    assign b = DW'(in_b);
    assign sa = f_sign(64'(a), DW);
    assign sb = f_sign(64'(b), DW);
    assign ea = E'(f_exp(64'(a), DW));
    assign eb = E'(f_exp(64'(b), DW));
    assign ma = M'(f_man(64'(a), DW));
    assign mb = M'(f_man(64'(b), DW));
    assign a_zero = ~|a[DW-2:0];
    assign b_zero = ~|b[DW-2:0];
    assign accept = in_valid && in_ready;

    float_frac_div #(.M(M)) u_frac (
        .clk(clk),
        .rst_n(rst_n),
        .start(accept && !a_zero && !b_zero),
        .a_m(ma),
        .b_m(mb),
        .done(div_done),
        .quotient(q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = accept ? ((a_zero || b_zero) ? DONE : DIV) : IDLE;
            DIV: state_n = div_done ? NORM : DIV;
            NORM: state_n = DONE;
            DONE: state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready = rst_n && state == IDLE;
        out_valid = state == DONE;
        out_c = DATA_WIDTH'(c_q);
        out_dbz = dbz_q;
    end

    // Zero dividend wins over zero divisor, so 0/0 yields +0 without the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            exp_q <= '0;
            c_q <= '0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            sign_q <= sa ^ sb;
            exp_q <= ea - eb + OFF;
            dbz_q <= !a_zero && b_zero;
            if (a_zero) c_q <= '0;
            else if (b_zero) c_q <= {sa ^ sb, {E{1'b1}}, {M{1'b0}}};
        end else if (state == NORM) begin
            c_q <= q[M+1] ? {sign_q, exp_q, q[M:1]} : {sign_q, exp_q - E'(1), q[M-1:0]};
            dbz_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_float_div_seq.sv
// tb_float_div_seq: directed vectors for F32 and F16 dividers, including backpressure and mid-operation reset.
module tb_float_div_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ordy = 1'b1;
    logic v32 = 1'b0, rdy32, ov32, dbz32;
    logic [31:0] a32 = '0, b32 = '0, c32;
    logic v16 = 1'b0, rdy16, ov16, dbz16;
    logic [15:0] a16 = '0, b16 = '0, c16;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    float_div_seq #(.DATA_WIDTH(32)) d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .in_a(a32), .in_b(b32),
        .out_valid(ov32), .out_ready(ordy), .out_c(c32), .out_dbz(dbz32)
    );

    float_div_seq #(.DATA_WIDTH(16)) d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16), .in_a(a16), .in_b(b16),
        .out_valid(ov16), .out_ready(ordy), .out_c(c16), .out_dbz(dbz16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Latency is counted in rising edges after the accept edge until out_valid is seen.
    task automatic op(input bit h, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ec, input bit ed, input int el);
        int lat;
        @(negedge clk);
        check("in_ready_before", h ? rdy16 : rdy32, 1);
        if (h) begin a16 = a[15:0]; b16 = b[15:0]; v16 = 1'b1; end
        else begin a32 = a; b32 = b; v32 = 1'b1; end
        @(posedge clk);
        #1;
        v16 = 1'b0;
        v32 = 1'b0;
        lat = 0;
        while (!(h ? ov16 : ov32) && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, el);
        check("out_c", h ? c16 : c32, ec);
        check("out_dbz", h ? dbz16 : dbz32, ed);
        if (ordy) begin
            @(posedge clk);
            #1;
            check("valid_drop", h ? ov16 : ov32, 0);
            check("in_ready_after", h ? rdy16 : rdy32, 1);
        end
    endtask

    initial begin
        #12;
        check("rst_in_ready", rdy32, 0);
        check("rst_out_valid", ov32, 0);
        check("rst_out_c", c32, 0);
        check("rst_out_dbz", dbz32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready32", rdy32, 1);
        check("rel_in_ready16", rdy16, 1);

        op(1, 32'h4600, 32'h4000, 32'h4200, 0, 13);
        op(0, 32'h40C00000, 32'h40000000, 32'h40400000, 0, 26);
        op(0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0, 26);
        op(0, 32'hC0F00000, 32'h40200000, 32'hC0400000, 0, 26);
        op(0, 32'h00000000, 32'h40A00000, 32'h00000000, 0, 0);
        op(0, 32'h40800000, 32'h80000000, 32'hFF800000, 1, 0);
        op(0, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0);

        ordy = 1'b0;
        op(0, 32'h40C00000, 32'h40000000, 32'h40400000, 0, 26);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            v32 = 1'b1;
            a32 = 32'h3F800000;
            b32 = 32'h40400000;
            @(posedge clk);
            #1;
            check("bp_out_c", c32, 32'h40400000);
            check("bp_out_valid", ov32, 1);
            check("bp_in_ready", rdy32, 0);
        end
        @(negedge clk);
        v32 = 1'b0;
        ordy = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", ov32, 0);
        check("bp_release_ready", rdy32, 1);
        @(posedge clk);
        #1;
        check("bp_no_accept", ov32, 0);

        @(negedge clk);
        a32 = 32'h40C00000; b32 = 32'h40000000; v32 = 1'b1;
        a16 = 16'h4600; b16 = 16'h4000; v16 = 1'b1;
        @(posedge clk);
        #1;
        v32 = 1'b0;
        v16 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid32", ov32, 0);
        check("mid_rst_c32", c32, 0);
        check("mid_rst_ready32", rdy32, 0);
        check("mid_rst_valid16", ov16, 0);
        check("mid_rst_c16", c16, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready32", rdy32, 1);
        check("mid_rel_ready16", rdy16, 1);
        op(0, 32'h40C00000, 32'h40000000, 32'h40400000, 0, 26);
        op(1, 32'h4600, 32'h4000, 32'h4200, 0, 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
